// File: rtl/parking_display_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : parking_display_scheduler_if
// Purpose  : Bundle of the request/payload/grant signals exchanged between
//            the message sources (gate alert, sections A/B) and the display
//            scheduler, plus the word/status handed on to the display driver.
// Signals  : req[2:0]          level request per source (bit 0 = gate alert)
//            data0/1/2[11:0]   payload per source, two 6-bit fields
//            ack[2:0]          one-cycle grant pulse, one-hot or zero
//            disp_word[11:0]   word shown on the display
//            disp_src[1:0]     index of the source shown, 2'b11 when idle
//            busy              high while a word is being shown
// Modports : master - source/driver side (drives req/data)
//            slave  - scheduler side (drives ack/disp_*/busy)
// Revision : 1.0 - initial release
// ============================================================================
interface parking_display_scheduler_if;
    logic [2:0]  req;
    logic [11:0] data0;
    logic [11:0] data1;
    logic [11:0] data2;
    logic [2:0]  ack;
    logic [11:0] disp_word;
    logic [1:0]  disp_src;
    logic        busy;

    modport master (
        output req, data0, data1, data2,
        input  ack, disp_word, disp_src, busy
    );

    modport slave (
        input  req, data0, data1, data2,
        output ack, disp_word, disp_src, busy
    );
endinterface
`default_nettype wire

// File: rtl/parking_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : parking_display_scheduler
// Purpose  : Time-shares the single 4-digit display among three sources.
//            Arbitrates requests (source 0 fixed highest priority, sources
//            1/2 round-robin), latches the winning payload and holds it for
//            DWELL_CYCLES clock cycles, switching back-to-back when another
//            request is pending at expiry.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - parking_display_scheduler_if.slave (req/data in,
//                   ack/disp_word/disp_src/busy out, all outputs registered)
// Params   : DWELL_CYCLES - cycles a granted word is shown (>= 2)
// Options  : DISP_PREEMPT_EN - when defined, a gate-alert request preempts a
//            section word that is currently on display.
// Revision : 1.0 - initial release
// ============================================================================
module parking_display_scheduler #(
    parameter int DWELL_CYCLES = 1024
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    parking_display_scheduler_if.slave bus
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [1:0]       c_src_idle = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    // Round-robin pointer between sections: 0 favours source 1, 1 favours source 2
    logic             r_rr;

    logic [2:0]  w_req;
    logic        w_any;
    logic        w_eval;
    logic        w_preempt;
    logic        w_take;
    logic [1:0]  w_idx;
    logic [11:0] w_data;

    // A source still sees its own ack on the cycle it drops req; ignoring
    // req while ack is high avoids granting the same request twice.
    assign w_req  = bus.req & ~bus.ack;
    assign w_any  = |w_req;
    assign w_eval = (r_state == S_IDLE) || (r_cnt == '0);

`ifdef DISP_PREEMPT_EN
    assign w_preempt = (r_state == S_SHOW) && (bus.disp_src != 2'd0) && w_req[0];
`else
    assign w_preempt = 1'b0;
`endif

    // Preemption only happens on req[0], which the arbiter already picks first
    assign w_take = (w_eval && w_any) || w_preempt;

    always_comb begin
        w_idx = 2'd0;
        if (w_req[0]) begin
            w_idx = 2'd0;
        end else if (w_req[1] && w_req[2]) begin
            w_idx = r_rr ? 2'd2 : 2'd1;
        end else if (w_req[1]) begin
            w_idx = 2'd1;
        end else if (w_req[2]) begin
            w_idx = 2'd2;
        end
    end

    always_comb begin
        w_data = bus.data0;
        case (w_idx)
            2'd1:    w_data = bus.data1;
            2'd2:    w_data = bus.data2;
            default: w_data = bus.data0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rr          <= 1'b0;
            bus.ack       <= 3'b000;
            bus.disp_word <= 12'h000;
            bus.disp_src  <= c_src_idle;
            bus.busy      <= 1'b0;
        end else begin
            bus.ack <= 3'b000;
            if (w_take) begin
                r_state       <= S_SHOW;
                r_cnt         <= c_cnt_load;
                bus.ack       <= 3'b001 << w_idx;
                bus.disp_word <= w_data;
                bus.disp_src  <= w_idx;
                bus.busy      <= 1'b1;
                if (w_idx == 2'd1) begin
                    r_rr <= 1'b1;
                end else if (w_idx == 2'd2) begin
                    r_rr <= 1'b0;
                end
            end else if (r_state == S_SHOW) begin
                if (r_cnt == '0) begin
                    // Expiry with nothing pending; the last word stays latched
                    r_state      <= S_IDLE;
                    bus.disp_src <= c_src_idle;
                    bus.busy     <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parking_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_display_scheduler
// Purpose  : Directed self-checking bench for parking_display_scheduler with
//            DWELL_CYCLES = 8. Expected values are hand-derived constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_display_scheduler;

    localparam int DWELL = 8;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    parking_display_scheduler_if bus_if ();

    parking_display_scheduler #(
        .DWELL_CYCLES (DWELL)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs changed afterwards apply to the next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_ack, input logic [11:0] e_word,
                           input logic [1:0] e_src, input logic e_busy);
        chk({tag, ".ack"},  {13'd0, bus_if.ack},       {13'd0, e_ack});
        chk({tag, ".word"}, {4'd0,  bus_if.disp_word}, {4'd0,  e_word});
        chk({tag, ".src"},  {14'd0, bus_if.disp_src},  {14'd0, e_src});
        chk({tag, ".busy"}, {15'd0, bus_if.busy},      {15'd0, e_busy});
    endtask

    task automatic do_reset();
        bus_if.req = 3'b000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus_if.req   = 3'b111;
        bus_if.data0 = 12'hA11;
        bus_if.data1 = 12'h111;
        bus_if.data2 = 12'h222;

        // ---------------- reset held 2 cycles with all requests high
        tick();
        tick();
        chk_out("reset", 3'b000, 12'h000, 2'd3, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("rst_rel", 3'b001, 12'hA11, 2'd0, 1'b1);

        // ---------------- single source
        do_reset();
        bus_if.req   = 3'b010;
        bus_if.data1 = 12'h0C5;
        tick();
        chk_out("single_grant", 3'b010, 12'h0C5, 2'd1, 1'b1);
        bus_if.req = 3'b000;
        for (int i = 0; i < DWELL - 1; i++) begin
            tick();
            chk($sformatf("single_busy%0d", i), {15'd0, bus_if.busy}, 16'd1);
        end
        tick();
        chk_out("single_idle", 3'b000, 12'h0C5, 2'd3, 1'b0);

        // ---------------- round-robin between sources 1 and 2
        do_reset();
        bus_if.data1 = 12'h111;
        bus_if.data2 = 12'h222;
        bus_if.req   = 3'b110;
        tick();
        chk_out("rr0", 3'b010, 12'h111, 2'd1, 1'b1);
        for (int g = 1; g < 4; g++) begin
            // granted source drops req for one cycle
            bus_if.req = (g % 2 == 1) ? 3'b100 : 3'b010;
            tick();
            bus_if.req = 3'b110;
            repeat (DWELL - 2) tick();
            chk($sformatf("rr%0d_gap_busy", g), {15'd0, bus_if.busy}, 16'd1);
            chk($sformatf("rr%0d_pre_ack", g), {13'd0, bus_if.ack}, 16'd0);
            tick();
            if (g % 2 == 1)
                chk_out($sformatf("rr%0d", g), 3'b100, 12'h222, 2'd2, 1'b1);
            else
                chk_out($sformatf("rr%0d", g), 3'b010, 12'h111, 2'd1, 1'b1);
        end

        // ---------------- priority: all three requesting from IDLE
        do_reset();
        bus_if.req = 3'b111;
        tick();
        chk_out("prio0", 3'b001, 12'hA11, 2'd0, 1'b1);
        bus_if.req = 3'b110;
        repeat (DWELL - 1) tick();
        chk("prio_wait_ack", {13'd0, bus_if.ack}, 16'd0);
        tick();
        chk_out("prio1", 3'b010, 12'h111, 2'd1, 1'b1);

        // ---------------- gate alert arriving during a section B display
        do_reset();
        bus_if.req = 3'b100;
        tick();
        chk_out("pre_show2", 3'b100, 12'h222, 2'd2, 1'b1);
        bus_if.req = 3'b000;
        tick();
        tick();
        bus_if.req = 3'b001;
        tick();
`ifdef DISP_PREEMPT_EN
        chk_out("preempt", 3'b001, 12'hA11, 2'd0, 1'b1);
        bus_if.req = 3'b000;
`else
        chk_out("no_preempt", 3'b000, 12'h222, 2'd2, 1'b1);
        repeat (DWELL - 4) tick();
        chk("no_preempt_wait", {13'd0, bus_if.ack}, 16'd0);
        tick();
        chk_out("expiry_grant0", 3'b001, 12'hA11, 2'd0, 1'b1);
        bus_if.req = 3'b000;
`endif

        // ---------------- reset in the middle of a display
        do_reset();
        bus_if.data1 = 12'h0C5;
        bus_if.req   = 3'b010;
        tick();
        chk_out("mid_grant", 3'b010, 12'h0C5, 2'd1, 1'b1);
        bus_if.req = 3'b000;
        tick();
        bus_if.req = 3'b010;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_out("mid_reset", 3'b000, 12'h000, 2'd3, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("mid_regrant", 3'b010, 12'h0C5, 2'd1, 1'b1);
        bus_if.req = 3'b000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parking_display_scheduler.md
# parking_display_scheduler

Time-shares the parking system's single 4-digit seven-segment display among three message sources: gate alert, section A occupancy and section B occupancy. It arbitrates requests, latches the winning 12-bit payload and holds it for a programmable dwell time. The latched word is forwarded to the seven-segment multiplexing driver as its `s1a` input. It sits between the gate/section counters and the display driver, and is the only writer of the displayed word.

## Interface
Parameters:
- `DWELL_CYCLES`, default 1024: number of `clk` cycles a granted word is shown. Legal range is 2 or more. The counter width is `$clog2(DWELL_CYCLES)`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  3: level request per source. Bit 0 is the gate alert (highest priority). Bits 1 and 2 are sections A and B.
- `data0`, `data1`, `data2`  in  12 each: payload of each source. Two 6-bit fields, `[11:6]` and `[5:0]`. Must be stable while the matching `req` bit is high.
- `ack`  out  3: one-cycle grant/capture pulse, one-hot or zero.
- `disp_word`  out  12: word driven to the display driver.
- `disp_src`  out  2: index of the source being shown; `2'b11` when idle.
- `busy`  out  1: high in SHOW.

## Operation
- All outputs are registered.
- Reset values: `ack` = 0, `disp_word` = 12'h000, `disp_src` = 2'b11, `busy` = 0. Internal state: FSM = IDLE, dwell counter = 0, round-robin pointer = source 1.
- FSM states:
  - IDLE: nothing granted.
  - SHOW: a word is on display and the dwell counter is running.
- Arbitration is evaluated in IDLE, and in SHOW on the cycle the dwell counter equals 0.
  - `req[0]` always wins.
  - Otherwise, if only one of `req[1]`/`req[2]` is high, it wins.
  - If both are high, the source selected by the round-robin pointer wins. The pointer then moves to the other source.
  - The pointer changes only on grants to source 1 or 2.
- Grant edge actions (all on the same edge):
  - `disp_word` <= `data[i]`
  - `disp_src` <= i
  - `ack[i]` <= 1
  - counter <= `DWELL_CYCLES-1`
  - state <= SHOW
  - `busy` <= 1
- SHOW:
  - The counter decrements each cycle.
  - At 0 with any unmasked request pending: grant directly, back-to-back, with no IDLE cycle.
  - At 0 with no request pending: go to IDLE. `disp_src` <= 2'b11, `busy` <= 0, and `disp_word` retains its last value.
- Request masking: `req[i]` is ignored on any cycle where `ack[i]` is high. A source drops `req` in response to `ack`. A `req` still high on the following cycle counts as a new request.
- `ack` is low on every cycle other than the pulse that follows a grant edge.
- Reset asserted mid-SHOW: all state returns to reset values on the next edge, with no ack. Sources still holding `req` are re-arbitrated after `rst` falls.

## Timing
- Request-to-display latency is 1 cycle. `req` is sampled at edge k; `ack`, `disp_word` and `disp_src` are valid in the cycle after edge k.
- A granted word is shown for exactly `DWELL_CYCLES` cycles when not preempted.
- Back-to-back switching inserts zero gap cycles.
- Minimum spacing between two acks to the same source is `DWELL_CYCLES` cycles.
- Request arriving during SHOW: it waits until the counter reaches 0. The exception is preemption under `DISP_PREEMPT_EN`.
- If requests arrive in IDLE and at the expiry edge in the same cycle, both are treated identically: the arbiter uses only the levels sampled on that edge.

## Configuration
- `DISP_PREEMPT_EN` defined:
  - In SHOW with `disp_src` ≠ 0 and `req[0]` high, source 0 is granted on the next edge regardless of the counter, and the counter is reloaded.
  - The preempted source gets no further notification. Its word is lost and it must re-request.
  - Source 0 never preempts itself.
- `DISP_PREEMPT_EN` undefined: no preemption. `req[0]` waits for dwell expiry like any other request and keeps only its priority.

## Test plan
(`DWELL_CYCLES` = 8 for all scenarios.)
- Reset: hold `rst` 2 cycles with all `req` high → `ack` = 0, `disp_word` = 12'h000, `disp_src` = 3, `busy` = 0. After release, `ack` = 3'b001 on the first cycle.
- Single source: `req[1]` = 1, `data1` = 12'h0C5 for 1 cycle → next cycle `ack` = 3'b010, `disp_word` = 12'h0C5, `disp_src` = 1. `busy` is high for exactly 8 cycles, then `disp_src` = 3 and `disp_word` stays 12'h0C5.
- Round-robin: hold `req[1]` and `req[2]` high, dropping each for one cycle after its ack → grants alternate 1, 2, 1, 2 at 8-cycle spacing with no idle gaps.
- Priority: `req[0]`, `req[1]` and `req[2]` all high in IDLE → source 0 is granted first. At its expiry, source 1 is granted because the pointer is at reset value.
- Preemption: source 2 is shown and `req[0]` rises at dwell cycle 3. With `DISP_PREEMPT_EN`, `ack` = 3'b001 on the next cycle and `disp_word` = `data0`. Without it, `ack[0]` fires exactly at expiry.
- Reset mid-SHOW: assert `rst` at dwell cycle 4 → next cycle all outputs are at reset values and there is no ack. After release, the pending `req` is granted 1 cycle later.
